// File: rtl/entity_drawer_pkg.sv
// Shared constants for the entity drawer: FSM state encoding, default screen size, palette.
// Pure declarations; no logic.
package entity_drawer_pkg;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_DRAW  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    localparam int DEF_SCR_W = 160;
    localparam int DEF_SCR_H = 120;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_BLUE  = 3'b001;
    localparam logic [2:0] COL_GREEN = 3'b010;

endpackage

// File: rtl/entity_drawer_if.sv
// Pixel write bus towards the VGA adapter: strobe, coordinate and colour.
// No handshake; the adapter takes every strobed pixel.
interface entity_drawer_if #(
    parameter int CW = 3
);
    logic          plot;
    logic [7:0]    xToVGA;
    logic [6:0]    yToVGA;
    logic [CW-1:0] cToVGA;

    modport master (output plot, xToVGA, yToVGA, cToVGA);
    modport slave  (input  plot, xToVGA, yToVGA, cToVGA);
endinterface

// File: rtl/entity_drawer_raster_counter.sv
// Two-level raster counter, x fastest; wraps to (0,0) after (x_lim,y_lim), o_last flags that point.
// Advances one position per cycle with i_step; no backpressure.
module entity_drawer_raster_counter #(
    parameter int XW = 4,
    parameter int YW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_step,
    input  logic [XW-1:0] i_x_lim,
    input  logic [YW-1:0] i_y_lim,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_last
);
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_x_end;

    assign w_x_end = (r_x == i_x_lim);
    assign o_last  = w_x_end && (r_y == i_y_lim);
    assign o_x     = r_x;
    assign o_y     = r_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_step) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= o_last ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end
endmodule

// File: rtl/entity_drawer.sv
// Frame renderer: snapshots entity slots, rasterises each enabled sprite, then clears on the frame tick.
// One pixel per cycle, pixel visible in the same cycle as its counters; the VGA side never stalls.
module entity_drawer
    import entity_drawer_pkg::*;
#(
    parameter int NUM_ENT = 3,
    parameter int SCR_W   = DEF_SCR_W,
    parameter int SCR_H   = DEF_SCR_H,
    parameter int SZW     = 4,
    parameter int CW      = 3
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   fps,
    input  logic [NUM_ENT-1:0]     ent_en,
    input  logic [NUM_ENT*8-1:0]   ent_x,
    input  logic [NUM_ENT*7-1:0]   ent_y,
    input  logic [NUM_ENT*SZW-1:0] ent_w,
    input  logic [NUM_ENT*SZW-1:0] ent_h,
    input  logic [NUM_ENT*CW-1:0]  ent_c,
    input  logic [CW-1:0]          bg_c,
    entity_drawer_if.master        vga,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);
    localparam int SELW  = $clog2(NUM_ENT + 1);
    localparam int SLOTS = 1 << SELW;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SELW-1:0]  r_sel;
    logic             r_pending;
    logic             r_overrun;

    // Slot tables padded to a power of two so r_sel indexes them without range checks.
    logic [SLOTS-1:0]     w_en_ext;
    logic [SLOTS*8-1:0]   w_x_ext;
    logic [SLOTS*7-1:0]   w_y_ext;
    logic [SLOTS*SZW-1:0] w_w_ext;
    logic [SLOTS*SZW-1:0] w_h_ext;
    logic [SLOTS*CW-1:0]  w_c_ext;

    logic [SLOTS-1:0] r_en;
    logic [7:0]       r_x [SLOTS];
    logic [6:0]       r_y [SLOTS];
    logic [SZW-1:0]   r_w [SLOTS];
    logic [SZW-1:0]   r_h [SLOTS];
    logic [CW-1:0]    r_c [SLOTS];
    logic [CW-1:0]    r_bg;

    logic [SZW-1:0] w_sx;
    logic [SZW-1:0] w_sy;
    logic           w_s_last;
    logic [7:0]     w_cx;
    logic [6:0]     w_cy;
    logic           w_c_last;
    logic [8:0]     w_wx;
    logic [7:0]     w_wy;

    assign w_en_ext = {{(SLOTS-NUM_ENT){1'b0}}, ent_en};
    assign w_x_ext  = {{(8*(SLOTS-NUM_ENT)){1'b0}}, ent_x};
    assign w_y_ext  = {{(7*(SLOTS-NUM_ENT)){1'b0}}, ent_y};
    assign w_w_ext  = {{(SZW*(SLOTS-NUM_ENT)){1'b0}}, ent_w};
    assign w_h_ext  = {{(SZW*(SLOTS-NUM_ENT)){1'b0}}, ent_h};
    assign w_c_ext  = {{(CW*(SLOTS-NUM_ENT)){1'b0}}, ent_c};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_en <= '0;
            r_bg <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
                r_w[i] <= '0;
                r_h[i] <= '0;
                r_c[i] <= '0;
            end
        end else if (r_state == ST_LOAD) begin
            r_en <= w_en_ext;
            r_bg <= bg_c;
            for (int i = 0; i < SLOTS; i++) begin
                r_x[i] <= w_x_ext[8*i +: 8];
                r_y[i] <= w_y_ext[7*i +: 7];
                r_w[i] <= w_w_ext[SZW*i +: SZW];
                r_h[i] <= w_h_ext[SZW*i +: SZW];
                r_c[i] <= w_c_ext[CW*i +: CW];
            end
        end
    end

    entity_drawer_raster_counter #(.XW(SZW), .YW(SZW)) u_sprite_cnt (
        .clk     (clock),
        .rst_n   (resetn),
        .i_clr   (r_state == ST_SCAN),
        .i_step  (r_state == ST_DRAW),
        .i_x_lim (r_w[r_sel]),
        .i_y_lim (r_h[r_sel]),
        .o_x     (w_sx),
        .o_y     (w_sy),
        .o_last  (w_s_last)
    );

    entity_drawer_raster_counter #(.XW(8), .YW(7)) u_clear_cnt (
        .clk     (clock),
        .rst_n   (resetn),
        .i_clr   (1'b0),
        .i_step  (r_state == ST_CLEAR),
        .i_x_lim (8'(SCR_W - 1)),
        .i_y_lim (7'(SCR_H - 1)),
        .o_x     (w_cx),
        .o_y     (w_cy),
        .o_last  (w_c_last)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= ST_LOAD;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD:  w_state_nxt = ST_SCAN;
            ST_SCAN: begin
                if (r_sel == SELW'(NUM_ENT)) w_state_nxt = ST_WAIT;
                else if (r_en[r_sel])        w_state_nxt = ST_DRAW;
            end
            ST_DRAW:  if (w_s_last)          w_state_nxt = ST_SCAN;
            ST_WAIT:  if (fps || r_pending)  w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (w_c_last)          w_state_nxt = ST_LOAD;
            default:  w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sel <= '0;
        end else begin
            case (r_state)
                ST_LOAD: r_sel <= '0;
                ST_SCAN: if (r_sel != SELW'(NUM_ENT) && !r_en[r_sel]) r_sel <= r_sel + SELW'(1);
                ST_DRAW: if (w_s_last) r_sel <= r_sel + SELW'(1);
                default: ;
            endcase
        end
    end

    // Only one tick is remembered; WAIT always hands off to CLEAR, so that is where pending drops.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= fps && r_pending;
            if (r_state == ST_WAIT) r_pending <= 1'b0;
            else if (fps)           r_pending <= 1'b1;
        end
    end

    assign w_wx    = 9'(r_x[r_sel]) + 9'(w_sx);
    assign w_wy    = 8'(r_y[r_sel]) + 8'(w_sy);
    assign overrun = r_overrun;

    always_comb begin
        vga.plot   = 1'b0;
        vga.xToVGA = '0;
        vga.yToVGA = '0;
        vga.cToVGA = CW'(COL_BLACK);
        busy       = (r_state != ST_WAIT);
        frame_done = 1'b0;
        case (r_state)
            ST_SCAN: frame_done = (r_sel == SELW'(NUM_ENT));
            ST_DRAW: begin
                vga.plot   = (w_wx < 9'(SCR_W)) && (w_wy < 8'(SCR_H));
                vga.xToVGA = w_wx[7:0];
                vga.yToVGA = w_wy[6:0];
                vga.cToVGA = r_c[r_sel];
            end
            ST_CLEAR: begin
                vga.plot   = 1'b1;
                vga.xToVGA = w_cx;
                vga.yToVGA = w_cy;
                vga.cToVGA = r_bg;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_entity_drawer.sv
// Bench for entity_drawer: expected per-cycle pixel stream built from the sprite list, plus
// directed scenarios and randomized frames with random frame ticks.
module tb_entity_drawer;
    import entity_drawer_pkg::*;

    localparam int N   = 3;
    localparam int SZW = 4;
    localparam int CW  = 3;
    localparam int SW  = DEF_SCR_W;
    localparam int SH  = DEF_SCR_H;

    logic               clock  = 1'b0;
    logic               resetn = 1'b0;
    logic               fps    = 1'b0;
    logic [N-1:0]       ent_en = '0;
    logic [N*8-1:0]     ent_x  = '0;
    logic [N*7-1:0]     ent_y  = '0;
    logic [N*SZW-1:0]   ent_w  = '0;
    logic [N*SZW-1:0]   ent_h  = '0;
    logic [N*CW-1:0]    ent_c  = '0;
    logic [CW-1:0]      bg_c   = '0;
    logic               busy;
    logic               frame_done;
    logic               overrun;

    entity_drawer_if #(.CW(CW)) vga ();

    entity_drawer #(.NUM_ENT(N), .SCR_W(SW), .SCR_H(SH), .SZW(SZW), .CW(CW)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .fps        (fps),
        .ent_en     (ent_en),
        .ent_x      (ent_x),
        .ent_y      (ent_y),
        .ent_w      (ent_w),
        .ent_h      (ent_h),
        .ent_c      (ent_c),
        .bg_c       (bg_c),
        .vga        (vga),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    // Frame configuration as seen at the LOAD edge.
    logic [N-1:0] c_en;
    int           c_x [N];
    int           c_y [N];
    int           c_w [N];
    int           c_h [N];
    int           c_c [N];
    int           c_bg;

    bit   m_pend;
    bit   m_ovr;
    logic [20:0] q [$];

    int k, o_plot, o_lx, o_ly, o_lk, o_fdk, o_ovr, o_wait;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {plot, x, y, colour, busy, frame_done}
    function automatic logic [20:0] ev(input bit p, input int x, input int y, input int c,
                                       input bit b, input bit fd);
        return {p, 8'(x), 7'(y), 3'(c), b, fd};
    endfunction

    function automatic logic [21:0] outs();
        return {vga.plot, vga.xToVGA, vga.yToVGA, vga.cToVGA, busy, frame_done, overrun};
    endfunction

    task automatic set_slot(input int i, input int x, input int y, input int w, input int h,
                            input int c);
        c_x[i] = x; c_y[i] = y; c_w[i] = w; c_h[i] = h; c_c[i] = c;
    endtask

    task automatic rand_cfg();
        c_en = N'($urandom_range(0, (1 << N) - 1));
        for (int i = 0; i < N; i++)
            set_slot(i, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 7));
        c_bg = $urandom_range(0, 7);
    endtask

    task automatic apply_cfg();
        ent_en = c_en;
        bg_c   = CW'(c_bg);
        for (int i = 0; i < N; i++) begin
            ent_x[8*i +: 8]     = 8'(c_x[i]);
            ent_y[7*i +: 7]     = 7'(c_y[i]);
            ent_w[SZW*i +: SZW] = SZW'(c_w[i]);
            ent_h[SZW*i +: SZW] = SZW'(c_h[i]);
            ent_c[CW*i +: CW]   = CW'(c_c[i]);
        end
    endtask

    task automatic scramble();
        ent_en = N'($urandom);
        ent_x  = (N*8)'($urandom);
        ent_y  = (N*7)'($urandom);
        ent_w  = (N*SZW)'($urandom);
        ent_h  = (N*SZW)'($urandom);
        ent_c  = (N*CW)'($urandom);
        bg_c   = CW'($urandom);
    endtask

    // Expected stream from LOAD through the last SCAN: one entry per cycle.
    task automatic build_q();
        int wx, wy;
        q.delete();
        q.push_back(ev(0, 0, 0, 0, 1, 0));
        for (int s = 0; s < N; s++) begin
            q.push_back(ev(0, 0, 0, 0, 1, 0));
            if (c_en[s]) begin
                for (int yy = 0; yy <= c_h[s]; yy++) begin
                    for (int xx = 0; xx <= c_w[s]; xx++) begin
                        wx = c_x[s] + xx;
                        wy = c_y[s] + yy;
                        q.push_back(ev(wx < SW && wy < SH, wx, wy, c_c[s], 1, 0));
                    end
                end
            end
        end
        q.push_back(ev(0, 0, 0, 0, 1, 1));
    endtask

    // Check the current cycle, drive fps for its closing edge, advance to the next cycle.
    task automatic cyc(input string tag, input logic [20:0] e, input bit wait_ph, input bit f);
        check_eq(tag, 32'(outs()), 32'({e, m_ovr}));
        if (vga.plot) begin
            o_plot++;
            o_lx = int'(vga.xToVGA);
            o_ly = int'(vga.yToVGA);
            o_lk = k;
        end
        if (frame_done) o_fdk = k;
        if (overrun)    o_ovr++;
        if (!busy)      o_wait++;
        fps   = f;
        m_ovr = f & m_pend;
        if (wait_ph)  m_pend = 1'b0;
        else if (f)   m_pend = 1'b1;
        k++;
        @(negedge clock);
    endtask

    task automatic start_frame();
        fps    = 1'b0;
        resetn = 1'b0;
        m_pend = 1'b0;
        m_ovr  = 1'b0;
        #1;
        check_eq("reset_async", 32'(outs()), 32'({ev(0, 0, 0, 0, 1, 0), 1'b0}));
        apply_cfg();
        @(negedge clock);
        check_eq("reset_hold", 32'(outs()), 32'({ev(0, 0, 0, 0, 1, 0), 1'b0}));
        resetn = 1'b1;
        k = 0; o_plot = 0; o_lx = -1; o_ly = -1; o_lk = -1; o_fdk = -1; o_ovr = 0; o_wait = 0;
    endtask

    task automatic run_frame(input int fa, input int fb, input int wfps, input int clear_n);
        bit leave, f;
        build_q();
        for (int i = 0; i < q.size(); i++) begin
            cyc("draw", q[i], 1'b0, (i == fa) || (i == fb));
            if (i == 0) scramble();
        end
        leave = 1'b0;
        for (int w = 0; w < 4 && !leave; w++) begin
            f     = (w == wfps);
            leave = f | m_pend;
            cyc("wait", ev(0, 0, 0, 0, 0, 0), 1'b1, f);
        end
        if (leave) begin
            for (int i = 0; i < clear_n; i++)
                cyc("clear", ev(1, i % SW, i / SW, c_bg, 1, 0), 1'b0, 1'b0);
            if (clear_n == SW * SH)
                cyc("reload", ev(0, 0, 0, 0, 1, 0), 1'b0, 1'b0);
        end
    endtask

    initial begin
        // Single 10x10 sprite in slot 0.
        rand_cfg();
        c_en = 3'b001;
        set_slot(0, 5, 7, 9, 9, COL_BLUE);
        start_frame();
        run_frame(-1, -1, -1, 0);
        check_eq("s0_plots", 32'(o_plot), 32'd100);
        check_eq("s0_last_x", 32'(o_lx), 32'd14);
        check_eq("s0_last_y", 32'(o_ly), 32'd16);
        check_eq("s0_fd_gap", 32'(o_fdk - o_lk), 32'd3);
        check_eq("s0_wait", 32'(o_wait), 32'd4);

        // Sprite straddling the right edge.
        rand_cfg();
        c_en = 3'b010;
        set_slot(1, 155, 0, 9, 0, COL_GREEN);
        start_frame();
        run_frame(-1, -1, -1, 0);
        check_eq("clip_plots", 32'(o_plot), 32'd5);
        check_eq("clip_last_x", 32'(o_lx), 32'd159);

        // Nothing enabled.
        rand_cfg();
        c_en = 3'b000;
        start_frame();
        run_frame(-1, -1, -1, 0);
        check_eq("empty_plots", 32'(o_plot), 32'd0);
        check_eq("empty_fd_at", 32'(o_fdk), 32'd4);

        // Tick during DRAW, second tick overruns, then a full clear.
        rand_cfg();
        c_en = 3'b001;
        set_slot(0, 20, 30, 1, 1, COL_BLUE);
        c_bg = COL_GREEN;
        start_frame();
        run_frame(2, 4, -1, SW * SH);
        check_eq("ovr_pulses", 32'(o_ovr), 32'd1);
        check_eq("ovr_wait", 32'(o_wait), 32'd1);
        check_eq("clr_plots", 32'(o_plot), 32'(4 + SW * SH));
        check_eq("clr_last", 32'({o_lx[15:0], o_ly[15:0]}), 32'({16'd159, 16'd119}));

        // Reset in the middle of a clear, then an ordinary redraw.
        rand_cfg();
        start_frame();
        run_frame(1, -1, -1, 80 * 1 + 60 * SW);
        check_eq("clr_mid", 32'({vga.plot, vga.xToVGA, vga.yToVGA}), 32'({1'b1, 8'd80, 7'd60}));
        for (int r = 0; r < 16; r++) begin
            rand_cfg();
            start_frame();
            run_frame(($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 60)) : -1,
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : -1,
                      $urandom_range(0, 5), 3);
        end
        resetn = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
